// File: rtl/seg_pkg.sv
// Shared types and constants for the key input and seven-segment display path.
package seg_pkg;

    localparam int NUM_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DN_CHK,
        S_HELD,
        S_UP_CHK
    } deb_state_t;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by hex digit 0..F.
    localparam logic [15:0][6:0] SEG_DIGITS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce FSM, single-cycle press pulse
// and a held level while the key is accepted as down.
module key_debounce
    import seg_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o,
    output logic held_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    deb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!sync2_q) begin
                        state_q <= S_DN_CHK;
                        cnt_q   <= '0;
                    end
                end
                S_DN_CHK: begin
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_HELD;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (sync2_q) begin
                        state_q <= S_UP_CHK;
                        cnt_q   <= '0;
                    end
                end
                S_UP_CHK: begin
                    // A low glitch during release returns to HELD without a new press.
                    if (!sync2_q) begin
                        state_q <= S_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign press_o = press_q;
    assign held_o  = (state_q == S_HELD);

endmodule

// File: rtl/key_num_ctrl.sv
// Button-driven 8-bit value source for the display driver (inc/dec/clr keys).
// Optional auto-repeat of held inc/dec keys: define KEY_NUM_AUTO_REPEAT_EN.
module key_num_ctrl
    import seg_pkg::*;
#(
    parameter int DEB_CYCLES   = 1000000,
    parameter int MAX_VAL      = 255,
    parameter int WRAP         = 0
`ifdef KEY_NUM_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_inc_n,
    input  logic             key_dec_n,
    input  logic             key_clr_n,
    output logic [NUM_W-1:0] num,
    output logic             num_upd
);

    localparam logic [NUM_W:0] MAX_W = (NUM_W + 1)'(MAX_VAL);

    logic inc_press, dec_press, clr_press;
    logic inc_held, dec_held, clr_held;
    logic inc_ev, dec_ev;

    logic [NUM_W-1:0] num_q, num_d;
    logic             upd_q, upd_d;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk(clk), .rst(rst), .key_n_i(key_inc_n), .press_o(inc_press), .held_o(inc_held)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
        .clk(clk), .rst(rst), .key_n_i(key_dec_n), .press_o(dec_press), .held_o(dec_held)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk(clk), .rst(rst), .key_n_i(key_clr_n), .press_o(clr_press), .held_o(clr_held)
    );

    function automatic logic [NUM_W-1:0] step_up(input logic [NUM_W-1:0] v);
        logic [NUM_W:0] s;
        s = {1'b0, v} + (NUM_W + 1)'(1);
        if (s > MAX_W) return (WRAP != 0) ? '0 : MAX_W[NUM_W-1:0];
        return s[NUM_W-1:0];
    endfunction

    function automatic logic [NUM_W-1:0] step_down(input logic [NUM_W-1:0] v);
        logic [NUM_W:0] s;
        s = {1'b0, v} - (NUM_W + 1)'(1);
        if (s[NUM_W]) return (WRAP != 0) ? MAX_W[NUM_W-1:0] : '0;
        return s[NUM_W-1:0];
    endfunction

`ifdef KEY_NUM_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    // Index 0 is inc, 1 is dec; counter is 0 in the cycle the key enters HELD.
    logic [1:0]       rep_held;
    logic [1:0]       rep_fire;
    logic [1:0]       rep_armed_q;
    logic [REP_W-1:0] rep_cnt_q [2];
    logic             unused_clr_held;

    assign rep_held        = {dec_held, inc_held};
    assign unused_clr_held = clr_held;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep_fire[i] = rep_held[i] &&
                (rep_cnt_q[i] == (rep_armed_q[i] ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY)));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || !rep_held[i]) begin
                rep_cnt_q[i]   <= '0;
                rep_armed_q[i] <= 1'b0;
            end else if (rep_fire[i]) begin
                rep_cnt_q[i]   <= REP_W'(1);
                rep_armed_q[i] <= 1'b1;
            end else begin
                rep_cnt_q[i] <= rep_cnt_q[i] + REP_W'(1);
            end
        end
    end

    assign inc_ev = inc_press | rep_fire[0];
    assign dec_ev = dec_press | rep_fire[1];
`else
    logic unused_held;

    assign unused_held = inc_held ^ dec_held ^ clr_held;
    assign inc_ev      = inc_press;
    assign dec_ev      = dec_press;
`endif

    always_comb begin
        num_d = num_q;
        if (clr_press) begin
            num_d = '0;
        end else if (inc_ev && dec_ev) begin
            num_d = num_q;
        end else if (inc_ev) begin
            num_d = step_up(num_q);
        end else if (dec_ev) begin
            num_d = step_down(num_q);
        end
        upd_d = (num_d != num_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q <= '0;
            upd_q <= 1'b0;
        end else begin
            num_q <= num_d;
            upd_q <= upd_d;
        end
    end

    assign num     = num_q;
    assign num_upd = upd_q;

endmodule

// File: tb/tb_key_num_ctrl.sv
// Directed bench for key_num_ctrl: a saturating 0..255 instance and a wrapping 0..9 instance.
module tb_key_num_ctrl;

    localparam int DEB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       inc0_n, dec0_n, clr0_n;
    logic       inc1_n, dec1_n, clr1_n;
    logic [7:0] num0, num1;
    logic       upd0, upd1;

    int errors = 0;
    int checks = 0;
    int upd_cnt0 = 0;
    int upd_cnt1 = 0;

    key_num_ctrl #(
        .DEB_CYCLES(DEB), .MAX_VAL(255), .WRAP(0)
`ifdef KEY_NUM_AUTO_REPEAT_EN
        , .REPEAT_DELAY(20), .REPEAT_RATE(8)
`endif
    ) dut0 (
        .clk(clk), .rst(rst), .key_inc_n(inc0_n), .key_dec_n(dec0_n),
        .key_clr_n(clr0_n), .num(num0), .num_upd(upd0)
    );

    key_num_ctrl #(
        .DEB_CYCLES(DEB), .MAX_VAL(9), .WRAP(1)
`ifdef KEY_NUM_AUTO_REPEAT_EN
        , .REPEAT_DELAY(20), .REPEAT_RATE(8)
`endif
    ) dut1 (
        .clk(clk), .rst(rst), .key_inc_n(inc1_n), .key_dec_n(dec1_n),
        .key_clr_n(clr1_n), .num(num1), .num_upd(upd1)
    );

    always @(negedge clk) begin
        if (upd0 === 1'b1) upd_cnt0++;
        if (upd1 === 1'b1) upd_cnt1++;
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_keys(input int d, input logic inc, input logic dec, input logic clr);
        if (d == 0) begin
            inc0_n = ~inc; dec0_n = ~dec; clr0_n = ~clr;
        end else begin
            inc1_n = ~inc; dec1_n = ~dec; clr1_n = ~clr;
        end
    endtask

    task automatic tap(input int d, input logic inc, input logic dec, input logic clr);
        @(negedge clk);
        set_keys(d, inc, dec, clr);
        repeat (10) @(negedge clk);
        set_keys(d, 1'b0, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    // k = index of the first sampled cycle with num_upd high; cycle 0 follows the first posedge.
    task automatic wait_upd(input int d, input int maxc, output int k);
        k = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (k < 0 && ((d == 0) ? upd0 : upd1) === 1'b1) k = i;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c;
        rst = 1'b1;
        set_keys(0, 1'b0, 1'b0, 1'b0);
        set_keys(1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_num0", int'(num0), 0);
        check("rst_upd0", int'(upd0), 0);
        check("rst_num1", int'(num1), 0);

        inc0_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold_num", int'(num0), 0);
        rst = 1'b0;
        wait_upd(0, 10, k);
        check("rst_rel_lat", k, 7);
        check("rst_rel_num", int'(num0), 1);
        inc0_n = 1'b1;
        repeat (12) @(negedge clk);

        tap(0, 1'b0, 1'b0, 1'b1);
        check("clr_num", int'(num0), 0);

        c = upd_cnt0;
        inc0_n = 1'b0;
        wait_upd(0, 10, k);
        check("inc_lat", k, 7);
        check("inc_num", int'(num0), 1);
`ifndef KEY_NUM_AUTO_REPEAT_EN
        repeat (100) @(negedge clk);
        check("hold_pulses", upd_cnt0 - c, 1);
        check("hold_num", int'(num0), 1);
`endif
        inc0_n = 1'b1;
        repeat (12) @(negedge clk);

        c = upd_cnt0;
        for (int b = 0; b < 3; b++) begin
            inc0_n = 1'b0;
            repeat (2) @(negedge clk);
            inc0_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        inc0_n = 1'b0;
        wait_upd(0, 10, k);
        check("bounce_lat", k, 7);
        inc0_n = 1'b1;
        repeat (12) @(negedge clk);
        check("bounce_pulses", upd_cnt0 - c, 1);
        check("bounce_num", int'(num0), 2);

        repeat (3) tap(0, 1'b1, 1'b0, 1'b0);
        check("to5_num", int'(num0), 5);

        c = upd_cnt0;
        tap(0, 1'b1, 1'b1, 1'b0);
        check("incdec_num", int'(num0), 5);
        check("incdec_pulses", upd_cnt0 - c, 0);

        c = upd_cnt0;
        tap(0, 1'b1, 1'b0, 1'b1);
        check("clrinc_num", int'(num0), 0);
        check("clrinc_pulses", upd_cnt0 - c, 1);

        c = upd_cnt0;
        tap(0, 1'b0, 1'b1, 1'b0);
        check("dec0_num", int'(num0), 0);
        check("dec0_pulses", upd_cnt0 - c, 0);

        c = upd_cnt0;
        tap(0, 1'b0, 1'b0, 1'b1);
        check("clr0_pulses", upd_cnt0 - c, 0);

        c = upd_cnt0;
        repeat (255) tap(0, 1'b1, 1'b0, 1'b0);
        check("to255_num", int'(num0), 255);
        check("to255_pulses", upd_cnt0 - c, 255);

        c = upd_cnt0;
        tap(0, 1'b1, 1'b0, 1'b0);
        check("sat_num", int'(num0), 255);
        check("sat_pulses", upd_cnt0 - c, 0);

        tap(0, 1'b0, 1'b1, 1'b0);
        check("dec255_num", int'(num0), 254);

        repeat (9) tap(1, 1'b1, 1'b0, 1'b0);
        check("w_to9_num", int'(num1), 9);
        c = upd_cnt1;
        tap(1, 1'b1, 1'b0, 1'b0);
        check("w_inc_num", int'(num1), 0);
        check("w_inc_pulses", upd_cnt1 - c, 1);
        c = upd_cnt1;
        tap(1, 1'b0, 1'b1, 1'b0);
        check("w_dec_num", int'(num1), 9);
        check("w_dec_pulses", upd_cnt1 - c, 1);
        tap(1, 1'b0, 1'b1, 1'b0);
        check("w_dec8_num", int'(num1), 8);

`ifdef KEY_NUM_AUTO_REPEAT_EN
        tap(0, 1'b0, 1'b0, 1'b1);
        c = upd_cnt0;
        inc0_n = 1'b0;
        repeat (62) @(negedge clk);
        inc0_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rep_pulses", upd_cnt0 - c, 6);
        check("rep_num", int'(num0), 6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
